// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - 5x5 sliding-window generator feeding a convolution adder tree.
// Four chained row-delay line buffers plus a 5x5 register window, gated to in-frame positions.
module conv_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  input  logic [DATA_WIDTH-1:0]      i_pixel,
  output logic [25*DATA_WIDTH-1:0]   o_window,
  output logic                       o_valid,
  output logic                       o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] MIN_COL  = CW'(4);
  localparam logic [RW-1:0] MIN_ROW  = RW'(4);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, done_q;

  logic [DATA_WIDTH-1:0] lb_mem [4][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_out [4];
  logic [DATA_WIDTH-1:0] win_q  [25];
  logic [DATA_WIDTH-1:0] win_d  [25];

  // Each buffer is addressed by col, so it always delays by exactly one row of accepted pixels.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      lb_out[j] = lb_mem[j][col_q];
    end
  end

  always_ff @(posedge clk) begin
    if (i_valid && !reset) begin
      lb_mem[0][col_q] <= i_pixel;
      for (int j = 1; j < 4; j++) begin
        lb_mem[j][col_q] <= lb_out[j-1];
      end
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_valid) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Shift every window row left; the new right column is the four delayed rows plus the live pixel.
  always_comb begin
    for (int k = 0; k < 25; k++) begin
      win_d[k] = win_q[k];
    end
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        win_d[5*r+c] = win_q[5*r+c+1];
      end
    end
    for (int r = 0; r < 4; r++) begin
      win_d[5*r+4] = lb_out[3-r];
    end
    win_d[24] = i_pixel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < 25; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= i_valid && (row_q >= MIN_ROW) && (col_q >= MIN_COL);
      done_q  <= i_valid && (row_q == LAST_ROW) && (col_q == LAST_COL);
      if (i_valid) begin
        for (int k = 0; k < 25; k++) begin
          win_q[k] <= win_d[k];
        end
      end
    end
  end

  always_comb begin
    o_window = '0;
    for (int k = 0; k < 25; k++) begin
      o_window[k*DATA_WIDTH +: DATA_WIDTH] = win_q[k];
    end
  end

  assign o_valid      = valid_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen.
// Frame-position model rebuilds each window from a stored image; literal taps pin the model.
module tb_conv_window_gen;

  localparam int DW = 16;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int NPIX = W * H;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               i_valid = 1'b0;
  logic [DW-1:0]      i_pixel = '0;
  logic [25*DW-1:0]   o_window;
  logic               o_valid;
  logic               o_frame_done;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int ndone  = 0;

  conv_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .i_pixel      (i_pixel),
    .o_window     (o_window),
    .o_valid      (o_valid),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: position in frame, image of this frame, expected outputs after each edge.
  logic [DW-1:0]    img [H][W];
  logic [25*DW-1:0] exp_win = '0;
  logic             exp_valid = 1'b0;
  logic             exp_done = 1'b0;
  bit               win_known = 1'b0;
  bit               model_live = 1'b0;
  int               mr = 0;
  int               mc = 0;

  always @(posedge clk) begin
    model_live = 1'b1;
    if (reset) begin
      mr = 0; mc = 0;
      exp_valid = 1'b0; exp_done = 1'b0;
      exp_win = '0; win_known = 1'b1;
    end else if (i_valid) begin
      img[mr][mc] = i_pixel;
      if (mr >= 4 && mc >= 4) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            exp_win[(5*r+c)*DW +: DW] = img[mr-4+r][mc-4+c];
        exp_valid = 1'b1;
        win_known = 1'b1;
        exp_done  = (mr == H-1) && (mc == W-1);
      end else begin
        exp_valid = 1'b0; exp_done = 1'b0; win_known = 1'b0;
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end
    end else begin
      exp_valid = 1'b0; exp_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checks++;
      if (o_valid !== exp_valid) begin
        errors++;
        $display("FAIL cyc_valid t=%0t act=%b exp=%b", $time, o_valid, exp_valid);
      end
      checks++;
      if (o_frame_done !== exp_done) begin
        errors++;
        $display("FAIL cyc_done t=%0t act=%b exp=%b", $time, o_frame_done, exp_done);
      end
      if (win_known) begin
        checks++;
        if (o_window !== exp_win) begin
          errors++;
          $display("FAIL cyc_window t=%0t tap24 act=%0d exp=%0d tap0 act=%0d exp=%0d", $time,
                   o_window[24*DW +: DW], exp_win[24*DW +: DW], o_window[0 +: DW], exp_win[0 +: DW]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic int tap(input int k);
    return int'(o_window[k*DW +: DW]);
  endfunction

  task automatic send(input logic v, input logic [DW-1:0] p);
    i_valid = v;
    i_pixel = p;
    @(posedge clk);
    #1;
    if (o_valid) nvalid++;
    if (o_frame_done) ndone++;
  endtask

  // mode 0: continuous, 1: alternating 1,0, 2: random gaps. idx: pixel value = raster index.
  task automatic run_frame(input int mode, input bit idx, input string tag);
    logic [DW-1:0] pix;
    nvalid = 0;
    ndone = 0;
    for (int n = 0; n < NPIX; n++) begin
      if (mode == 1 && n > 0) send(1'b0, DW'($urandom));
      if (mode == 2) begin
        while ($urandom_range(0, 3) == 0) send(1'b0, DW'($urandom));
      end
      pix = idx ? DW'(n) : DW'($urandom);
      send(1'b1, pix);
      if (n == 115) chk({tag, "_no_early_valid"}, nvalid, 0);
      if (idx) begin
        case (n)
          115: chk({tag, "_valid_n115"}, int'(o_valid), 0);
          116: begin
            chk({tag, "_valid_n116"}, int'(o_valid), 1);
            chk({tag, "_tap0"}, tap(0), 0);
            chk({tag, "_tap4"}, tap(4), 4);
            chk({tag, "_tap12"}, tap(12), 58);
            chk({tag, "_tap20"}, tap(20), 112);
            chk({tag, "_tap24"}, tap(24), 116);
          end
          140, 141, 142, 143: chk({tag, "_rowwrap_valid"}, int'(o_valid), 0);
          144: begin
            chk({tag, "_valid_n144"}, int'(o_valid), 1);
            chk({tag, "_n144_tap0"}, tap(0), 28);
            chk({tag, "_n144_tap24"}, tap(24), 144);
          end
          782: chk({tag, "_done_n782"}, int'(o_frame_done), 0);
          783: begin
            chk({tag, "_done_n783"}, int'(o_frame_done), 1);
            chk({tag, "_valid_n783"}, int'(o_valid), 1);
            chk({tag, "_last_tap24"}, tap(24), 783);
            chk({tag, "_last_tap0"}, tap(0), 667);
          end
          default: ;
        endcase
      end
    end
    if (mode != 0) send(1'b0, DW'($urandom));
    chk({tag, "_valid_count"}, nvalid, (W-4)*(H-4));
    chk({tag, "_done_count"}, ndone, 1);
  endtask

  initial begin
    reset = 1'b1;
    i_valid = 1'b1;
    i_pixel = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_done", int'(o_frame_done), 0);
    chk("reset_window_zero", int'(o_window == '0), 1);
    reset = 1'b0;
    i_valid = 1'b0;

    run_frame(0, 1'b1, "frame_a");
    run_frame(0, 1'b1, "frame_b");
    run_frame(1, 1'b1, "toggle");

    for (int n = 0; n <= 200; n++) send(1'b1, DW'($urandom));
    reset = 1'b1;
    send(1'b1, DW'($urandom));
    chk("midreset_valid", int'(o_valid), 0);
    chk("midreset_window_zero", int'(o_window == '0), 1);
    reset = 1'b0;
    run_frame(2, 1'b1, "after_reset");

    run_frame(2, 1'b0, "rand_a");
    run_frame(0, 1'b0, "rand_b");
    repeat (3) send(1'b0, DW'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 16: bit width of each signed fixed-point pixel and window tap (Q8.8).
REQ-002 Parameter IMG_WIDTH, default 28: pixels per image row; legal range 5..1024.
REQ-003 Parameter IMG_HEIGHT, default 28: rows per frame; legal range 5..1024.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port i_valid  input  1: i_pixel is accepted on any rising edge where i_valid=1 (no backpressure).
REQ-007 Port i_pixel  input  DATA_WIDTH: signed pixel, raster order, row-major, top-left first.
REQ-008 Port o_window  output  25*DATA_WIDTH: flattened 5x5 window; tap k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port o_valid  output  1: o_window holds a complete in-frame 5x5 window this cycle.
REQ-010 Port o_frame_done  output  1: single-cycle pulse marking the last window of a frame.

Function
REQ-011 The block SHALL supply the 25 data inputs of the 5x5 adder tree; tap k = window row r, column c, with k = 5*r + c, r=0 the oldest (top) row, c=0 the oldest (leftmost) column.
REQ-012 The block SHALL hold four chained line buffers, each IMG_WIDTH deep, plus a 5x5 register window; all advance only on accepted pixels.
REQ-013 The block SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), giving the position of the next pixel to be accepted.
REQ-014 On each accepted pixel, col SHALL increment; at IMG_WIDTH-1 it wraps to 0 and row increments; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0 (frame boundary).
REQ-015 Latency SHALL be one cycle: o_valid=1 in the cycle after an accepted pixel located at row>=4 and col>=4; o_window is the window whose bottom-right tap (k=24) is that pixel.
REQ-016 o_valid SHALL be 0 in any cycle not immediately preceded by an accepted pixel; o_window holds its last value when no pixel is accepted.
REQ-017 Windows straddling a row wrap (col<4) or a frame boundary (row<4 of the new frame) SHALL never be flagged valid; stale line-buffer data from the previous frame is suppressed by this gating only, not cleared.
REQ-018 o_frame_done SHALL equal 1 in the same cycle as the o_valid for pixel (IMG_HEIGHT-1, IMG_WIDTH-1), and 0 otherwise.
REQ-019 Valid windows per frame SHALL be exactly (IMG_WIDTH-4)*(IMG_HEIGHT-4): 576 at defaults.
REQ-020 Pixel data SHALL pass unmodified (no arithmetic, no sign change); back-to-back frames SHALL need no idle cycles between them.

Reset
REQ-021 While reset=1: col=0, row=0, o_valid=0, o_frame_done=0, o_window=0, window registers=0; i_valid is ignored.
REQ-022 Line-buffer storage need not be cleared by reset; REQ-017 gating guarantees no invalid window is flagged.
REQ-023 After a reset in mid-frame, the first accepted pixel SHALL be treated as (0,0) of a new frame.

Verification (defaults, pixel value = pixel index n = row*28+col)
REQ-024 Continuous i_valid, one frame -> first o_valid the cycle after n=116 (row 4, col 4); taps 0=0, 4=4, 12=58, 20=112, 24=116.
REQ-025 Row wrap -> no o_valid after n=140..143 (row 5, cols 0..3); o_valid after n=144 with tap 0=28, tap 24=144.
REQ-026 Full frame -> exactly 576 o_valid pulses; one o_frame_done, coincident with the last o_valid, tap 24=783, tap 0=667.
REQ-027 i_valid toggled 1,0,1,0 -> same window sequence as REQ-024; o_valid only after accepted pixels; o_window stable in gaps.
REQ-028 Two back-to-back frames -> no o_valid for second-frame n=0..115; first second-frame o_valid after its n=116 with the REQ-024 tap values.
REQ-029 Reset asserted for 1 cycle after n=200, then new frame restarts at n=0 -> o_valid=0 during reset; first valid after n=116 of new frame; 576 valids, one o_frame_done.
